// File: rtl/multiplier2_if.sv
// Handshake and data bundle between the microcode sequencer and the multiplier.
// master: sequencer side, which drives ce/start/mode/operands and observes the status.
// slave : multiplier side, which drives busy/done/product/ovf.
interface multiplier2_if #(
    parameter int WIDTH = 16
);
    logic                 ce;         // clock enable; the multiplier advances only when high
    logic                 start;      // begin operation (sampled while ce=1)
    logic                 wide;       // 1 = full-width operands, 0 = half-width operands
    logic                 is_signed;  // 1 = two's complement (IMUL), 0 = unsigned (MUL)
    logic [WIDTH-1:0]     a;          // multiplicand
    logic [WIDTH-1:0]     b;          // multiplier
    logic                 busy;       // operation in progress
    logic                 done;       // result valid, held until the next start
    logic [2*WIDTH-1:0]   product;    // result
    logic                 ovf;        // upper half significant (CF/OF)

    modport master (
        output ce, start, wide, is_signed, a, b,
        input  busy, done, product, ovf
    );

    modport slave (
        input  ce, start, wide, is_signed, a, b,
        output busy, done, product, ovf
    );
endinterface

// File: rtl/multiplier2.sv
// Iterative shift-add multiplier for MUL/IMUL, 8x8 or 16x16, signed or unsigned.
// Latency: done rises 17 ce-cycles (wide) or 9 ce-cycles (narrow) after start is sampled.
// Backpressure: ce=0 freezes all state; start restarts from any state; done drops while start is high.
//
// Ports: clk, reset_n (async active-low) plus the multiplier2_if slave bundle:
//   ce/start/wide/is_signed/a/b in; busy/done/product/ovf out.
module multiplier2 #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    multiplier2_if.slave   bus
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          state_q,   state_d;
    logic                wide_q,    wide_d;
    logic                signed_q,  signed_d;
    logic                neg_q,     neg_d;      // result must be negated in FIX
    logic [WIDTH-1:0]    mcand_q,   mcand_d;    // multiplicand magnitude
    // Accumulator: upper half collects partial sums, lower half starts as the
    // multiplier magnitude and is consumed one bit per iteration.
    logic [2*WIDTH-1:0]  acc_q,     acc_d;
    logic [CW-1:0]       cnt_q,     cnt_d;
    logic                done_q,    done_d;
    logic [2*WIDTH-1:0]  product_q, product_d;
    logic                ovf_q,     ovf_d;

    // ------------------------------------------------------------------
    // Operand capture: sign and magnitude of the incoming operands
    // ------------------------------------------------------------------
    logic             a_sign, b_sign;
    logic [WIDTH-1:0] a_neg_w, b_neg_w;
    logic [HALF-1:0]  a_neg_n, b_neg_n;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_sign  = bus.wide ? bus.a[WIDTH-1] : bus.a[HALF-1];
        b_sign  = bus.wide ? bus.b[WIDTH-1] : bus.b[HALF-1];
        a_neg_w = -bus.a;
        b_neg_w = -bus.b;
        a_neg_n = -bus.a[HALF-1:0];
        b_neg_n = -bus.b[HALF-1:0];

        // Narrow mode zero-extends the half-width magnitude so garbage in the
        // upper operand bits never reaches the datapath.
        if (bus.wide) begin
            a_mag = (bus.is_signed && a_sign) ? a_neg_w : bus.a;
            b_mag = (bus.is_signed && b_sign) ? b_neg_w : bus.b;
        end else begin
            a_mag = {{HALF{1'b0}}, ((bus.is_signed && a_sign) ? a_neg_n : bus.a[HALF-1:0])};
            b_mag = {{HALF{1'b0}}, ((bus.is_signed && b_sign) ? b_neg_n : bus.b[HALF-1:0])};
        end
    end

    // ------------------------------------------------------------------
    // One shift-add iteration
    // ------------------------------------------------------------------
    logic [WIDTH:0]      sum;        // includes the carry out of the add
    logic [2*WIDTH-1:0]  acc_shift;

    always_comb begin
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        // Shifting {carry, acc} right by one drops the consumed multiplier bit.
        acc_shift = {sum, acc_q[WIDTH-1:1]};
    end

    // ------------------------------------------------------------------
    // Sign fix-up and overflow
    // ------------------------------------------------------------------
    // After HALF iterations a half-width product sits at acc[WIDTH+HALF-1:HALF];
    // after WIDTH iterations the full product fills the accumulator.
    logic [2*WIDTH-1:0]  res_w;
    logic [WIDTH-1:0]    mag_n, res_n;
    logic [2*WIDTH-1:0]  fix_prod;
    logic                fix_ovf;

    always_comb begin
        mag_n    = acc_q[WIDTH+HALF-1:HALF];
        res_w    = neg_q ? -acc_q : acc_q;
        res_n    = neg_q ? -mag_n : mag_n;
        fix_prod = wide_q ? res_w : {{WIDTH{1'b0}}, res_n};

        if (wide_q) begin
            if (signed_q)
                fix_ovf = fix_prod[2*WIDTH-1:WIDTH] != {WIDTH{fix_prod[WIDTH-1]}};
            else
                fix_ovf = fix_prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}};
        end else begin
            if (signed_q)
                fix_ovf = fix_prod[WIDTH-1:HALF] != {HALF{fix_prod[HALF-1]}};
            else
                fix_ovf = fix_prod[WIDTH-1:HALF] != {HALF{1'b0}};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wide_d    = wide_q;
        signed_d  = signed_q;
        neg_d     = neg_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        product_d = product_q;
        ovf_d     = ovf_q;

        if (bus.ce) begin
            if (bus.start) begin
                // Start wins over whatever is in flight, so a restart simply
                // reloads everything. product/ovf are kept until the next FIX.
                wide_d   = bus.wide;
                signed_d = bus.is_signed;
                neg_d    = bus.is_signed && (a_sign ^ b_sign);
                mcand_d  = a_mag;
                acc_d    = {{WIDTH{1'b0}}, b_mag};
                cnt_d    = bus.wide ? CW'(WIDTH) : CW'(HALF);
                done_d   = 1'b0;
                state_d  = S_RUN;
            end else begin
                case (state_q)
                    S_RUN: begin
                        acc_d = acc_shift;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CW'(1))
                            state_d = S_FIX;
                    end
                    S_FIX: begin
                        product_d = fix_prod;
                        ovf_d     = fix_ovf;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end
                    S_IDLE: begin
                        state_d = S_IDLE;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wide_q    <= 1'b0;
            signed_q  <= 1'b0;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wide_q    <= wide_d;
            signed_q  <= signed_d;
            neg_q     <= neg_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy    = (state_q == S_RUN) || (state_q == S_FIX);
    // A new start hides the stale result immediately, before the edge.
    assign bus.done    = done_q & ~bus.start;
    assign bus.product = product_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_multiplier2.sv
// Scoreboard bench for multiplier2: expected results queued at start, compared at done.
// Latency is measured in ce-high edges after the start edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_multiplier2;
    logic clk;
    logic reset_n;

    multiplier2_if #(.WIDTH(16)) mif();

    multiplier2 #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q_prod[$];
    logic        q_ovf[$];
    int          q_lat[$];
    logic [31:0] prev_prod = '0;
    logic        prev_ovf  = 1'b0;
    bit          have_done = 1'b0;
    bit          ce_toggle = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain integer multiplication of the sign-interpreted operands.
    function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic w, input logic s);
        longint      pa, pb, p;
        logic [7:0]  a8, b8;
        logic [31:0] r;
        logic        o;
        a8 = a[7:0];
        b8 = b[7:0];
        if (w) begin
            pa = s ? longint'($signed(a)) : longint'(a);
            pb = s ? longint'($signed(b)) : longint'(b);
        end else begin
            pa = s ? longint'($signed(a8)) : longint'(a8);
            pb = s ? longint'($signed(b8)) : longint'(b8);
        end
        p = pa * pb;
        if (w) begin
            r = p[31:0];
            o = s ? (p < -32768 || p > 32767) : (p > 65535);
        end else begin
            r = {16'h0000, p[15:0]};
            o = s ? (p < -128 || p > 127) : (p > 255);
        end
        return {o, r};
    endfunction

    // Present start for one edge (ce=1); optionally queue the expected result.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic w,
                            input logic s, input bit push, input logic [31:0] ep, input logic eo);
        @(negedge clk);
        mif.a = a; mif.b = b; mif.wide = w; mif.is_signed = s;
        mif.ce = 1'b1; mif.start = 1'b1;
        #1;
        if (have_done) check("done_drop", {31'b0, mif.done}, 32'd0);
        if (push) begin
            q_prod.push_back(ep);
            q_ovf.push_back(eo);
            q_lat.push_back(w ? 17 : 9);
        end
        @(posedge clk);
        #1;
        have_done = 1'b0;
    endtask

    // Run idle cycles with start low, scrambling the operand inputs.
    task automatic idle_cycle(input logic ce_val);
        @(negedge clk);
        mif.start = 1'b0;
        mif.a = 16'($urandom); mif.b = 16'($urandom);
        mif.wide = 1'($urandom); mif.is_signed = 1'($urandom);
        mif.ce = ce_val;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            idle_cycle(ce_toggle ? i[0] : 1'b1);
            if (mif.ce) lat++;
            if (mif.done) seen = 1'b1;
            else begin
                check("hold_prod", mif.product, prev_prod);
                check("hold_ovf", {31'b0, mif.ovf}, {31'b0, prev_ovf});
                check("busy", {31'b0, mif.busy}, 32'd1);
            end
        end
        mif.ce = 1'b1;
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        if (q_prod.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            logic [31:0] ep;
            logic        eo;
            int          el;
            ep = q_prod.pop_front();
            eo = q_ovf.pop_front();
            el = q_lat.pop_front();
            check("product", mif.product, ep);
            check("ovf", {31'b0, mif.ovf}, {31'b0, eo});
            check("latency", lat, el);
            check("busy_idle", {31'b0, mif.busy}, 32'd0);
            prev_prod = ep;
            prev_ovf  = eo;
            have_done = 1'b1;
        end
    endtask

    initial begin
        logic [32:0] m;
        logic [15:0] ra, rb;
        logic        rw, rs;

        reset_n = 1'b0;
        mif.ce = 1'b0; mif.start = 1'b0; mif.wide = 1'b0; mif.is_signed = 1'b0;
        mif.a = '0; mif.b = '0;
        #1;
        check("rst_busy", {31'b0, mif.busy}, 32'd0);
        check("rst_done", {31'b0, mif.done}, 32'd0);
        check("rst_product", mif.product, 32'd0);
        check("rst_ovf", {31'b0, mif.ovf}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Wide and narrow vectors
        start_op(16'hFFFF, 16'h0002, 1'b1, 1'b0, 1'b1, 32'h0001FFFE, 1'b1); wait_done();
        start_op(16'hFFFF, 16'h0002, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0); wait_done();
        start_op(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1, 32'h40000000, 1'b1); wait_done();
        start_op(16'hAB80, 16'hCD80, 1'b0, 1'b1, 1'b1, 32'h00004000, 1'b1); wait_done();
        start_op(16'h550F, 16'hAA10, 1'b0, 1'b0, 1'b1, 32'h000000F0, 1'b0); wait_done();

        // ce toggling: latency counted in ce-high edges, outputs held meanwhile
        ce_toggle = 1'b1;
        start_op(16'h1234, 16'hFFFE, 1'b1, 1'b1, 1'b1, 32'hFFFFDB98, 1'b0); wait_done();
        ce_toggle = 1'b0;

        // Restart mid-run: only the second operation completes
        start_op(16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle_cycle(1'b1);
            check("restart_nodone", {31'b0, mif.done}, 32'd0);
        end
        start_op(16'h0007, 16'h0009, 1'b1, 1'b0, 1'b1, 32'h0000003F, 1'b0); wait_done();
        for (int i = 0; i < 20; i++) begin
            idle_cycle(1'b1);
            check("done_held", {31'b0, mif.done}, 32'd1);
        end
        check("restart_product", mif.product, 32'h0000003F);

        // Random operations against the integer model
        for (int k = 0; k < 6; k++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rw = 1'($urandom);  rs = 1'($urandom);
            m  = model(ra, rb, rw, rs);
            start_op(ra, rb, rw, rs, 1'b1, m[31:0], m[32]);
            wait_done();
        end

        // Asynchronous reset mid-run
        start_op(16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (5) idle_cycle(1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, mif.busy}, 32'd0);
        check("arst_done", {31'b0, mif.done}, 32'd0);
        check("arst_product", mif.product, 32'd0);
        check("arst_ovf", {31'b0, mif.ovf}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        prev_prod = '0;
        prev_ovf  = 1'b0;
        have_done = 1'b0;
        start_op(16'h0002, 16'h0003, 1'b1, 1'b0, 1'b1, 32'h00000006, 1'b0); wait_done();

        check("sb_empty", q_prod.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
